imm_gen_stage: RTL and testbench

- Pipelined, parametrised immediate generator for the decode stage.
- Accepts a full instruction word over a valid/ready handshake and decodes every RV32I/RV64I immediate format: I, S, B, U, J and shift-amount.
- Delivers the XLEN-wide extended immediate, a format code and the instruction one cycle later.
- A 2-entry skid buffer absorbs execute-side backpressure without combinational ready paths.

---
 rtl/imm_gen_stage_if.sv | 25 ++
 rtl/imm_gen_stage.sv | 169 ++++++++++++++++
 tb/tb_imm_gen_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage: instruction in, decoded immediate out.
// The stage is the slave; the surrounding pipeline (or bench) is the master.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_out;
  logic [2:0]      fmt_out;
  logic [31:0]     instr_out;

  modport master (
    output flush, in_valid, instr_in, out_ready,
    input  in_ready, out_valid, imm_out, fmt_out, instr_out
  );

  modport slave (
    input  flush, in_valid, instr_in, out_ready,
    output in_ready, out_valid, imm_out, fmt_out, instr_out
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: combinational RV32I/RV64I immediate decode
// feeding a 2-entry (output + skid) buffer with a registered in_ready.
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_stage_if.slave bus
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
      $error("imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [31:0]     instr;
  } entry_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  fmt_e        dec_fmt;
  entry_t      dec_entry;

  assign instr  = bus.instr_in;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Every format is built as a 32-bit value whose bit 31 is the sign; widening
  // to XLEN is then a single signed cast (shamt is zero-extended, so bit 31 is 0).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    dec_fmt = FMT_NONE;
    imm32   = '0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        dec_fmt = FMT_I;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          imm32   = {{(32-SHAMT_W){1'b0}}, instr[20 +: SHAMT_W]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    dec_entry.imm   = XLEN'($signed(imm32));
    dec_entry.fmt   = dec_fmt;
    dec_entry.instr = instr;
  end

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  logic in_fire, out_fire, out_free;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;
  assign out_free = !out_valid_q || out_fire;

  // The skid entry is only ever filled while the output is stalled, so it is
  // always older than anything arriving later and drains first (FIFO order).
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
        if (in_fire) begin
          skid_d       = dec_entry;
          skid_valid_d = 1'b1;
        end
      end else if (in_fire) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset too, not just the valids, because
      // imm_out/fmt_out/instr_out must read as zero straight out of reset.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // settled before the edge, independent of statement order.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.imm_out   = out_q.imm;
  assign bus.fmt_out   = out_q.fmt;
  assign bus.instr_out = out_q.instr;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance,
// hand-computed immediates, backpressure, flush and asynchronous reset.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32)) bus32 ();
  imm_gen_stage_if #(.XLEN(64)) bus64 ();

  imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", bus32.out_valid); end
    n_cmp++; if (bus32.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b expected 1", bus32.in_ready); end
    n_cmp++; if (bus32.imm_out !== 32'h0) begin n_err++; $display("FAIL reset imm_out: got %h expected 0", bus32.imm_out); end
    n_cmp++; if (bus32.fmt_out !== 3'd0) begin n_err++; $display("FAIL reset fmt_out: got %0d expected 0", bus32.fmt_out); end
    n_cmp++; if (bus32.instr_out !== 32'h0) begin n_err++; $display("FAIL reset instr_out: got %h expected 0", bus32.instr_out); end
    n_cmp++; if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || bus64.imm_out !== 64'h0) begin
      n_err++; $display("FAIL reset64: got valid=%b ready=%b imm=%h expected 0/1/0", bus64.out_valid, bus64.in_ready, bus64.imm_out);
    end
    #1 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_formats();
    logic [31:0] w   [6] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h0000006F, 32'h8000006F};
    logic [31:0] imm [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000000, 32'hFFF00000};
    logic [2:0]  fmt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus32.instr_in = w[i];
      bus32.in_valid = 1'b1;
      next_cycle();
      bus32.in_valid = 1'b0;
      n_cmp++; if (bus32.out_valid !== 1'b1) begin n_err++; $display("FAIL fmt[%0d] out_valid: got %b expected 1", i, bus32.out_valid); end
      n_cmp++; if (bus32.imm_out !== imm[i]) begin n_err++; $display("FAIL fmt[%0d] imm_out: got %h expected %h", i, bus32.imm_out, imm[i]); end
      n_cmp++; if (bus32.fmt_out !== fmt[i]) begin n_err++; $display("FAIL fmt[%0d] fmt_out: got %0d expected %0d", i, bus32.fmt_out, fmt[i]); end
      n_cmp++; if (bus32.instr_out !== w[i]) begin n_err++; $display("FAIL fmt[%0d] instr_out: got %h expected %h", i, bus32.instr_out, w[i]); end
    end
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL fmt drain out_valid: got %b expected 0", bus32.out_valid); end
  endtask

  task automatic test_shamt();
    logic [31:0] w32   [3] = '{32'h4030D093, 32'h01F09093, 32'h03F09093};
    logic [31:0] imm32 [3] = '{32'h00000003, 32'h0000001F, 32'h0000001F};
    logic [31:0] w64   [2] = '{32'h03F09093, 32'h4030D093};
    logic [63:0] imm64 [2] = '{64'h000000000000003F, 64'h0000000000000003};
    bus32.out_ready = 1'b1;
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus32.instr_in = w32[i];
      bus32.in_valid = 1'b1;
      next_cycle();
      bus32.in_valid = 1'b0;
      n_cmp++; if (bus32.imm_out !== imm32[i] || bus32.fmt_out !== 3'd6) begin
        n_err++; $display("FAIL shamt32[%0d]: got imm=%h fmt=%0d expected imm=%h fmt=6", i, bus32.imm_out, bus32.fmt_out, imm32[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      bus64.instr_in = w64[i];
      bus64.in_valid = 1'b1;
      next_cycle();
      bus64.in_valid = 1'b0;
      n_cmp++; if (bus64.out_valid !== 1'b1 || bus64.imm_out !== imm64[i] || bus64.fmt_out !== 3'd6) begin
        n_err++; $display("FAIL shamt64[%0d]: got v=%b imm=%h fmt=%0d expected v=1 imm=%h fmt=6", i, bus64.out_valid, bus64.imm_out, bus64.fmt_out, imm64[i]);
      end
    end
    next_cycle();
  endtask

  task automatic test_xlen64();
    logic [31:0] w   [5] = '{32'h800000B7, 32'hFFF00093, 32'hFE000CE3, 32'h123450B7, 32'h8000006F};
    logic [63:0] imm [5] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8,
                             64'h0000000012345000, 64'hFFFFFFFFFFF00000};
    logic [2:0]  fmt [5] = '{3'd4, 3'd1, 3'd3, 3'd4, 3'd5};
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus64.instr_in = w[i];
      bus64.in_valid = 1'b1;
      next_cycle();
      bus64.in_valid = 1'b0;
      n_cmp++; if (bus64.imm_out !== imm[i]) begin n_err++; $display("FAIL x64[%0d] imm_out: got %h expected %h", i, bus64.imm_out, imm[i]); end
      n_cmp++; if (bus64.fmt_out !== fmt[i] || bus64.instr_out !== w[i]) begin
        n_err++; $display("FAIL x64[%0d] fmt/instr: got %0d/%h expected %0d/%h", i, bus64.fmt_out, bus64.instr_out, fmt[i], w[i]);
      end
    end
    next_cycle();
  endtask

  task automatic test_unknown();
    bus32.out_ready = 1'b1;
    bus32.instr_in  = 32'h0000007F;
    bus32.in_valid  = 1'b1;
    next_cycle();
    bus32.in_valid  = 1'b0;
    n_cmp++; if (bus32.out_valid !== 1'b1) begin n_err++; $display("FAIL unknown out_valid: got %b expected 1", bus32.out_valid); end
    n_cmp++; if (bus32.fmt_out !== 3'd0) begin n_err++; $display("FAIL unknown fmt_out: got %0d expected 0", bus32.fmt_out); end
    n_cmp++; if (bus32.imm_out !== 32'h0) begin n_err++; $display("FAIL unknown imm_out: got %h expected 0", bus32.imm_out); end
    n_cmp++; if (bus32.instr_out !== 32'h0000007F) begin n_err++; $display("FAIL unknown instr_out: got %h expected 0000007f", bus32.instr_out); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bus32.out_ready = 1'b1;
    for (int k = 5; k < 9; k++) begin
      bus32.instr_in = (32'(k) << 20) | 32'h00000093;
      bus32.in_valid = 1'b1;
      next_cycle();
      n_cmp++; if (bus32.out_valid !== 1'b1 || bus32.imm_out !== 32'(k) || bus32.in_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b[%0d]: got v=%b imm=%h rdy=%b expected v=1 imm=%h rdy=1", k, bus32.out_valid, bus32.imm_out, bus32.in_ready, 32'(k));
      end
    end
    bus32.in_valid = 1'b0;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b drain out_valid: got %b expected 0", bus32.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a = 32'h00100093;
    logic [31:0] b = 32'h00200113;
    logic [31:0] c = 32'h00300193;
    bus32.out_ready = 1'b0;
    bus32.instr_in  = a;
    bus32.in_valid  = 1'b1;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b1 || bus32.instr_out !== a || bus32.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp A: got v=%b instr=%h rdy=%b expected v=1 instr=%h rdy=1", bus32.out_valid, bus32.instr_out, bus32.in_ready, a);
    end
    bus32.instr_in = b;
    next_cycle();
    n_cmp++; if (bus32.in_ready !== 1'b0 || bus32.instr_out !== a) begin
      n_err++; $display("FAIL bp B skid: got rdy=%b instr=%h expected rdy=0 instr=%h", bus32.in_ready, bus32.instr_out, a);
    end
    bus32.instr_in = c;
    next_cycle();
    n_cmp++; if (bus32.in_ready !== 1'b0 || bus32.instr_out !== a || bus32.imm_out !== 32'h1) begin
      n_err++; $display("FAIL bp hold: got rdy=%b instr=%h imm=%h expected rdy=0 instr=%h imm=1", bus32.in_ready, bus32.instr_out, bus32.imm_out, a);
    end
    bus32.out_ready = 1'b1;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b1 || bus32.instr_out !== b || bus32.imm_out !== 32'h2 || bus32.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp out B: got v=%b instr=%h imm=%h rdy=%b expected v=1 instr=%h imm=2 rdy=1", bus32.out_valid, bus32.instr_out, bus32.imm_out, bus32.in_ready, b);
    end
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b1 || bus32.instr_out !== c || bus32.imm_out !== 32'h3) begin
      n_err++; $display("FAIL bp out C: got v=%b instr=%h imm=%h expected v=1 instr=%h imm=3", bus32.out_valid, bus32.instr_out, bus32.imm_out, c);
    end
    bus32.in_valid = 1'b0;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL bp drain out_valid: got %b expected 0", bus32.out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] e = 32'h00A00093;
    bus32.out_ready = 1'b0;
    bus32.instr_in  = 32'h00100093;
    bus32.in_valid  = 1'b1;
    next_cycle();
    bus32.instr_in  = 32'h00200113;
    next_cycle();
    n_cmp++; if (bus32.in_ready !== 1'b0) begin n_err++; $display("FAIL flush precond in_ready: got %b expected 0", bus32.in_ready); end
    bus32.instr_in = 32'h00300193;
    bus32.flush    = 1'b1;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush full: got v=%b rdy=%b expected v=0 rdy=1", bus32.out_valid, bus32.in_ready);
    end
    bus32.flush     = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL flush residue out_valid: got %b expected 0", bus32.out_valid); end
    bus32.instr_in = 32'h00400093;
    bus32.in_valid = 1'b1;
    bus32.flush    = 1'b1;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush drops input: got v=%b rdy=%b expected v=0 rdy=1", bus32.out_valid, bus32.in_ready);
    end
    bus32.flush    = 1'b0;
    bus32.instr_in = e;
    next_cycle();
    bus32.in_valid = 1'b0;
    n_cmp++; if (bus32.out_valid !== 1'b1 || bus32.instr_out !== e || bus32.imm_out !== 32'hA) begin
      n_err++; $display("FAIL post-flush word: got v=%b instr=%h imm=%h expected v=1 instr=%h imm=a", bus32.out_valid, bus32.instr_out, bus32.imm_out, e);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    bus32.out_ready = 1'b0;
    bus32.instr_in  = 32'h00500093;
    bus32.in_valid  = 1'b1;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b1) begin n_err++; $display("FAIL areset precond out_valid: got %b expected 1", bus32.out_valid); end
    bus32.instr_in = 32'h00600093;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.imm_out !== 32'h0 || bus32.instr_out !== 32'h0) begin
      n_err++; $display("FAIL areset immediate: got v=%b rdy=%b imm=%h instr=%h expected 0/1/0/0", bus32.out_valid, bus32.in_ready, bus32.imm_out, bus32.instr_out);
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    #2 rst_n = 1'b1;
    next_cycle();
    n_cmp++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL areset no partial output: got %b expected 0", bus32.out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.instr_in = '0; bus32.out_ready = 1'b0;
    bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.instr_in = '0; bus64.out_ready = 1'b0;
    test_reset();
    test_formats();
    test_shamt();
    test_xlen64();
    test_unknown();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
